// File: rtl/shift_sequencer.sv
// Multi-cycle 16-bit shifter/rotator: one single-position shift or rotate per clock,
// with a start/busy/done handshake and an err pulse for starts that arrive while busy.
module shift_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] In,
    input  logic [3:0]  Cnt,
    input  logic [1:0]  Op,
    output logic [15:0] Out,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t      state_r, next_state_s;
    logic [15:0] data_r, data_nxt_s;
    logic [3:0]  rem_r, rem_nxt_s;
    logic [1:0]  op_r, op_nxt_s;
    logic        err_r, err_nxt_s;

    // One barrel-shifter stage worth of movement; must match the combinational path bit for bit.
    function automatic logic [15:0] step(input logic [15:0] d, input logic [1:0] op);
        logic [15:0] r;
        case (op)
            2'b00:   r = {d[14:0], d[15]};
            2'b01:   r = {d[14:0], 1'b0};
            2'b10:   r = {d[15], d[15:1]};
            2'b11:   r = {1'b0, d[15:1]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Next-state, datapath and err decode.
    always_comb begin
        next_state_s = IDLE;
        data_nxt_s   = data_r;
        rem_nxt_s    = rem_r;
        op_nxt_s     = op_r;
        err_nxt_s    = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    data_nxt_s   = In;
                    rem_nxt_s    = Cnt;
                    op_nxt_s     = Op;
                    next_state_s = (Cnt == 4'd0) ? DONE : SHIFT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SHIFT: begin
                data_nxt_s = step(data_r, op_r);
                rem_nxt_s  = rem_r - 4'd1;
                err_nxt_s  = start;
                if (rem_r == 4'd1) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; rst discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            data_r  <= 16'h0000;
            rem_r   <= 4'd0;
            op_r    <= 2'b00;
            err_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            data_r  <= data_nxt_s;
            rem_r   <= rem_nxt_s;
            op_r    <= op_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    assign Out  = data_r;
    assign busy = (state_r == SHIFT);
    assign done = (state_r == DONE);
    assign err  = err_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] in_v = 16'h0000;
    logic [3:0]  cnt_v = 4'd0;
    logic [1:0]  op_v = 2'b00;
    logic [15:0] out_v;
    logic        busy, done, err;

    int errors = 0;
    int checks = 0;

    shift_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .In(in_v), .Cnt(cnt_v), .Op(op_v),
        .Out(out_v), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept an operation at the next edge, then follow it to its done cycle.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [1:0] o,
                          input logic [3:0] n, input logic [15:0] exp);
        int busy_cycles;
        int guard;
        in_v = a; op_v = o; cnt_v = n; start = 1'b1;
        tick();
        start = 1'b0;
        busy_cycles = 0;
        guard = 0;
        while (done !== 1'b1 && guard < 40) begin
            if (busy === 1'b1) busy_cycles++;
            tick();
            guard++;
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
        chk({tag, "_out"}, {16'd0, out_v}, {16'd0, exp});
        chk({tag, "_busy_cycles"}, busy_cycles, {28'd0, n});
    endtask

    initial begin
        // reset and idle
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        chk("rst_out", {16'd0, out_v}, 32'd0);
        chk("rst_flags", {29'd0, busy, done, err}, 32'd0);

        // reset in the middle of a long shift
        in_v = 16'h1234; op_v = 2'b01; cnt_v = 4'd10; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_out", {16'd0, out_v}, 32'd0);
        chk("abort_flags", {29'd0, busy, done, err}, 32'd0);
        tick();
        chk("abort_no_done", {29'd0, busy, done, err}, 32'd0);

        run_op("rol1",  16'h8001, 2'b00, 4'd1,  16'h0003);
        tick();
        chk("idle_after_done", {30'd0, busy, done}, 32'd0);
        chk("out_held", {16'd0, out_v}, 32'h0003);
        run_op("sll8",  16'h00FF, 2'b01, 4'd8,  16'hFF00);
        tick();
        run_op("sra4",  16'h8000, 2'b10, 4'd4,  16'hF800);
        tick();
        run_op("srl15", 16'h8000, 2'b11, 4'd15, 16'h0001);
        tick();
        run_op("cnt0",  16'hA5A5, 2'b10, 4'd0,  16'hA5A5);
        tick();

        // start pulsed twice while shifting
        in_v = 16'h1234; op_v = 2'b11; cnt_v = 4'd4; start = 1'b1;
        tick();                                  // E0
        chk("err_e0", {31'd0, err}, 32'd0);
        in_v = 16'hFFFF; op_v = 2'b00; cnt_v = 4'd0;
        tick();                                  // E1, start while busy
        chk("err_e1", {31'd0, err}, 32'd1);
        tick();                                  // E2, start while busy
        start = 1'b0;
        chk("err_e2", {31'd0, err}, 32'd1);
        tick();                                  // E3
        chk("err_e3", {31'd0, err}, 32'd0);
        chk("busy_e3", {30'd0, busy, done}, 32'd2);
        tick();                                  // E4
        chk("err_done", {31'd0, done}, 32'd1);
        chk("err_out", {16'd0, out_v}, 32'h0123);

        // back-to-back start in the DONE cycle
        run_op("b2b", 16'h0001, 2'b01, 4'd3, 16'h0008);
        tick();
        chk("b2b_idle", {30'd0, busy, done}, 32'd0);
        chk("b2b_hold", {16'd0, out_v}, 32'h0008);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
